// File: rtl/mybusmatrix5x7_in_hold_if.sv
// Master-side AHB bus signals of one bus-matrix master port.
// The slave modport is the view taken by the input stage; the master modport
// is the view of whatever drives the port (the master or a testbench).
interface mybusmatrix5x7_in_hold_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic [1:0]            HRESPS;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/mybusmatrix5x7_in_hold.sv
// Master-side input stage of the 5x7 AHB bus matrix (one per master port).
// A transfer that is not granted in its address phase is captured in a
// holding register and re-presented to the decoder/output stages until an
// output stage accepts it; the master is stalled meanwhile. A data_phase flag
// tracks when the serving slave's ready and response belong to this port.
module mybusmatrix5x7_in_hold #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  mybusmatrix5x7_in_hold_if.slave ahb,

  input  logic                  active_op,
  input  logic                  readyout_op,
  input  logic [1:0]            resp_op,

  output logic                  sel_op,
  output logic [ADDR_WIDTH-1:0] addr_op,
  output logic [1:0]            trans_op,
  output logic                  write_op,
  output logic [2:0]            size_op,
  output logic [2:0]            burst_op,
  output logic [3:0]            prot_op,
  output logic                  lock_op,
  output logic                  held_tran_op
);

  // Address-phase control of one transfer, as captured in the holding register.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } tran_t;

  tran_t live_tran;
  tran_t hold_q, hold_d;
  logic  held_tran_q, held_tran_d;
  logic  data_phase_q, data_phase_d;
  logic  new_tran;
  logic  accept;

  // Bundle the live master inputs so they can be captured in one assignment.
  always_comb begin
    live_tran.addr  = ahb.HADDRS;
    live_tran.trans = ahb.HTRANSS;
    live_tran.write = ahb.HWRITES;
    live_tran.size  = ahb.HSIZES;
    live_tran.burst = ahb.HBURSTS;
    live_tran.prot  = ahb.HPROTS;
    live_tran.lock  = ahb.HMASTLOCKS;
  end

  // Only NONSEQ/SEQ start a transfer; IDLE/BUSY are never held.
  assign new_tran = ahb.HSELS & ahb.HREADYS & ahb.HTRANSS[1];
  assign accept   = active_op & readyout_op;

  // Present the held transfer while one is pending, else pass the live one.
  always_comb begin
    sel_op   = 1'b0;
    trans_op = 2'b00;
    addr_op  = live_tran.addr;
    write_op = live_tran.write;
    size_op  = live_tran.size;
    burst_op = live_tran.burst;
    prot_op  = live_tran.prot;
    lock_op  = live_tran.lock;
    if (held_tran_q) begin
      sel_op   = 1'b1;
      trans_op = hold_q.trans;
      addr_op  = hold_q.addr;
      write_op = hold_q.write;
      size_op  = hold_q.size;
      burst_op = hold_q.burst;
      prot_op  = hold_q.prot;
      lock_op  = hold_q.lock;
    end else begin
      sel_op   = ahb.HSELS & ahb.HREADYS;
      trans_op = sel_op ? live_tran.trans : 2'b00;
    end
  end

  // Next state of the holding register and the data-phase flag.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    hold_d       = hold_q;
    held_tran_d  = held_tran_q;
    data_phase_d = data_phase_q;

    if (held_tran_q) begin
      if (accept) held_tran_d = 1'b0;
    end else if (new_tran && !accept) begin
      hold_d      = live_tran;
      held_tran_d = 1'b1;
    end

    // A fresh accept wins over completion, keeping back-to-back beats in the
    // data phase.
    if (accept && sel_op && trans_op[1]) begin
      data_phase_d = 1'b1;
    end else if (readyout_op) begin
      data_phase_d = 1'b0;
    end
  end

  // State registers; an asynchronous reset discards any held transfer.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: the holding register is reset along with the flags so its
      // contents are defined even though they are only used while held.
      hold_q       <= '0;
      held_tran_q  <= 1'b0;
      data_phase_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // values computed before the clock edge.
      hold_q       <= hold_d;
      held_tran_q  <= held_tran_d;
      data_phase_q <= data_phase_d;
    end
  end

  assign held_tran_op   = held_tran_q;
  assign ahb.HREADYOUTS = held_tran_q ? 1'b0 : (data_phase_q ? readyout_op : 1'b1);
  assign ahb.HRESPS     = (data_phase_q && !held_tran_q) ? resp_op : 2'b00;

endmodule
